// File: rtl/dual_rail_rx_if.sv
// Link bundle for dual_rail_rx: dual-rail input, acknowledge, and the
// decoded valid/ready output side.
interface dual_rail_rx_if #(
   parameter int unsigned WIDTH = 2
);
   logic [WIDTH-1:0][1:0] in;
   logic                  ack;
   logic [WIDTH-1:0]      data_o;
   logic                  valid_o;
   logic                  ready_i;
   logic                  err_o;

   modport master (
      input  in, ready_i,
      output ack, data_o, valid_o, err_o
   );

   modport slave (
      output in, ready_i,
      input  ack, data_o, valid_o, err_o
   );
endinterface

// File: rtl/dual_rail_rx.sv
// Dual-rail link receiver: synchronises the rails, detects codeword completion
// (four-phase RTZ or two-phase transition) and emits decoded words on valid/ready.
module dual_rail_rx #(
   parameter              ENC         = "TP",
   parameter int unsigned WIDTH       = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            rst,
   dual_rail_rx_if.master link
);
   localparam bit          IS_FP  = (ENC == "FP");
   localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef logic [WIDTH-1:0][1:0] rails_t;
   typedef enum logic [1:0] {WAIT_DATA, HOLD, WAIT_SPACER} state_t;

   rails_t           sync_q [SYNC_N];
   rails_t           s;
   rails_t           s_d;
   rails_t           ref_q;
   state_t           state;
   logic             ack_q;
   logic             valid_q;
   logic             err_q;
   logic [WIDTH-1:0] data_q;

   logic             stable;
   logic             complete;
   logic             empty;
   logic             illegal;
   logic             swapped;
   logic [WIDTH-1:0] word;
   logic [1:0]       sym;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_N; i++) sync_q[i] <= '0;
         s_d <= '0;
      end else begin
         sync_q[0] <= link.in;
         for (int unsigned i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
         s_d <= s;
      end
   end

   always_comb s = sync_q[SYNC_N-1];

   // FP symbols are the raw rails; TP symbols are the rail toggles since the last token.
   // In FP, ref_q holds the captured codeword so a 01<->10 swap without spacer is caught.
   always_comb begin
      stable   = (s == s_d);
      complete = 1'b1;
      empty    = 1'b1;
      illegal  = 1'b0;
      swapped  = 1'b0;
      word     = '0;
      sym      = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (IS_FP) begin
            sym     = s[i];
            swapped = swapped | ((s[i] != 2'b00) && (s[i] != ref_q[i]));
         end else begin
            sym = s[i] ^ ref_q[i];
         end
         word[i] = sym[1];
         if (sym == 2'b00) complete = 1'b0;
         else              empty    = 1'b0;
         if (sym == 2'b11) illegal  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= WAIT_DATA;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
         ref_q   <= '0;
      end else begin
         // Draining stays possible in every state, including HOLD.
         if (valid_q && link.ready_i) valid_q <= 1'b0;
         case (state)
            WAIT_DATA: begin
               if (stable) begin
                  if (illegal) begin
                     err_q <= 1'b1;
                     state <= HOLD;
                  end else if (complete && (!valid_q || link.ready_i)) begin
                     data_q  <= word;
                     valid_q <= 1'b1;
                     ref_q   <= s;
                     if (IS_FP) begin
                        ack_q <= 1'b1;
                        state <= WAIT_SPACER;
                     end else begin
                        ack_q <= ~ack_q;
                     end
                  end
               end
            end
            WAIT_SPACER: begin
               if (stable) begin
                  if (illegal || swapped) begin
                     err_q <= 1'b1;
                     state <= HOLD;
                  end else if (empty) begin
                     ack_q <= 1'b0;
                     state <= WAIT_DATA;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign link.ack     = ack_q;
   assign link.valid_o = valid_q;
   assign link.data_o  = data_q;
   assign link.err_o   = err_q;
endmodule

// File: tb/tb_dual_rail_rx.sv
// Bench for dual_rail_rx: one FP and one TP instance (WIDTH=2, SYNC_STAGES=2)
// checked against codeword-level expectations and a queue of sent words.
module tb_dual_rail_rx;
   typedef logic [1:0][1:0] rails_t;
   localparam int LAT = 4;

   logic   clk = 1'b0;
   logic   rst;
   int     checks   = 0;
   int     failures = 0;
   rails_t tp_rails;

   dual_rail_rx_if #(.WIDTH(2)) fp_if ();
   dual_rail_rx_if #(.WIDTH(2)) tp_if ();

   dual_rail_rx #(.ENC("FP"), .WIDTH(2), .SYNC_STAGES(2)) u_fp (
      .clk  (clk),
      .rst  (rst),
      .link (fp_if)
   );

   dual_rail_rx #(.ENC("TP"), .WIDTH(2), .SYNC_STAGES(2)) u_tp (
      .clk  (clk),
      .rst  (rst),
      .link (tp_if)
   );

   always #5 clk = ~clk;

   function automatic rails_t fp_rails(input logic [1:0] w);
      rails_t r;
      for (int i = 0; i < 2; i++) r[i] = w[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic rails_t tp_next(input rails_t cur, input logic [1:0] w);
      rails_t r;
      r = cur;
      for (int i = 0; i < 2; i++) r[i] = r[i] ^ (w[i] ? 2'b10 : 2'b01);
      return r;
   endfunction

   task automatic do_reset();
      rst           = 1'b1;
      fp_if.in      = '0;
      tp_rails      = '0;
      tp_if.in      = '0;
      fp_if.ready_i = 1'b1;
      tp_if.ready_i = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // lat = negedges until valid_o is seen high, 0 on timeout
   task automatic wait_valid(input bit tp, output int lat);
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if ((tp ? tp_if.valid_o : fp_if.valid_o) === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic wait_ack(input bit tp, input logic lvl, input int budget, output int lat);
      lat = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if ((tp ? tp_if.ack : fp_if.ack) === lvl) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({fp_if.ack, fp_if.valid_o, fp_if.data_o, fp_if.err_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_fp: got ack=%b valid=%b data=%b err=%b, want all 0",
                  fp_if.ack, fp_if.valid_o, fp_if.data_o, fp_if.err_o);
      end
      checks++;
      if ({tp_if.ack, tp_if.valid_o, tp_if.data_o, tp_if.err_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_tp: got ack=%b valid=%b data=%b err=%b, want all 0",
                  tp_if.ack, tp_if.valid_o, tp_if.data_o, tp_if.err_o);
      end
   endtask

   task automatic test_fp_basic();
      int lat;
      fp_if.ready_i = 1'b1;
      fp_if.in      = fp_rails(2'b10);
      wait_valid(1'b0, lat);
      checks++;
      if (lat !== LAT) begin
         failures++;
         $display("FAIL fp_latency: got %0d, want %0d", lat, LAT);
      end
      checks++;
      if (fp_if.data_o !== 2'b10 || fp_if.ack !== 1'b1) begin
         failures++;
         $display("FAIL fp_word: got data=%b ack=%b, want data=10 ack=1", fp_if.data_o, fp_if.ack);
      end
      @(negedge clk);
      checks++;
      if (fp_if.valid_o !== 1'b0) begin
         failures++;
         $display("FAIL fp_valid_pulse: got valid=%b, want 0", fp_if.valid_o);
      end
      fp_if.in = '0;
      wait_ack(1'b0, 1'b0, 12, lat);
      checks++;
      if (lat !== LAT) begin
         failures++;
         $display("FAIL fp_spacer_ack: ack fell after %0d cycles, want %0d", lat, LAT);
      end
   endtask

   task automatic test_tp_basic();
      int lat;
      tp_if.ready_i = 1'b1;
      tp_rails      = tp_next(tp_rails, 2'b01);
      tp_if.in      = tp_rails;
      wait_valid(1'b1, lat);
      checks++;
      if (lat !== LAT || tp_if.data_o !== 2'b01 || tp_if.ack !== 1'b1) begin
         failures++;
         $display("FAIL tp_first: got lat=%0d data=%b ack=%b, want lat=%0d data=01 ack=1",
                  lat, tp_if.data_o, tp_if.ack, LAT);
      end
      tp_rails = tp_next(tp_rails, 2'b11);
      tp_if.in = tp_rails;
      @(negedge clk);
      wait_valid(1'b1, lat);
      checks++;
      if (tp_if.data_o !== 2'b11 || tp_if.ack !== 1'b0 || lat == 0) begin
         failures++;
         $display("FAIL tp_second: got lat=%0d data=%b ack=%b, want data=11 ack=0",
                  lat, tp_if.data_o, tp_if.ack);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      fp_if.ready_i = 1'b0;
      fp_if.in      = fp_rails(2'b11);
      wait_valid(1'b0, lat);
      checks++;
      if (lat !== LAT || fp_if.data_o !== 2'b11 || fp_if.ack !== 1'b1) begin
         failures++;
         $display("FAIL bp_first: got lat=%0d data=%b ack=%b, want lat=%0d data=11 ack=1",
                  lat, fp_if.data_o, fp_if.ack, LAT);
      end
      fp_if.in = '0;
      wait_ack(1'b0, 1'b0, 12, lat);
      checks++;
      if (lat !== LAT) begin
         failures++;
         $display("FAIL bp_spacer: ack fell after %0d cycles, want %0d", lat, LAT);
      end
      fp_if.in = fp_rails(2'b00);
      repeat (8) @(negedge clk);
      checks++;
      if (fp_if.ack !== 1'b0 || fp_if.data_o !== 2'b11 || fp_if.valid_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_held: got ack=%b data=%b valid=%b, want ack=0 data=11 valid=1",
                  fp_if.ack, fp_if.data_o, fp_if.valid_o);
      end
      fp_if.ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (fp_if.ack !== 1'b1 || fp_if.data_o !== 2'b00 || fp_if.valid_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: got ack=%b data=%b valid=%b, want ack=1 data=00 valid=1",
                  fp_if.ack, fp_if.data_o, fp_if.valid_o);
      end
      fp_if.in = '0;
      wait_ack(1'b0, 1'b0, 12, lat);
   endtask

   task automatic test_skew();
      int         pulses = 0;
      int         early  = 0;
      logic [1:0] got    = 'x;
      fp_if.ready_i = 1'b1;
      fp_if.in      = 4'b0010;
      repeat (3) begin
         @(negedge clk);
         if (fp_if.valid_o === 1'b1) early++;
      end
      fp_if.in = fp_rails(2'b01);
      repeat (12) begin
         @(negedge clk);
         if (fp_if.valid_o === 1'b1) begin
            pulses++;
            got = fp_if.data_o;
         end
         if (fp_if.valid_o === 1'b1 && early == 0 && pulses == 1) ;
      end
      checks++;
      if (early != 0 || pulses != 1 || got !== 2'b01 || fp_if.err_o !== 1'b0) begin
         failures++;
         $display("FAIL skew: got early=%0d pulses=%0d data=%b err=%b, want 0/1/01/0",
                  early, pulses, got, fp_if.err_o);
      end
      fp_if.in = '0;
      wait_ack(1'b0, 1'b0, 12, pulses);
   endtask

   task automatic test_random(input bit tp, input int n);
      logic [1:0] exp_q[$];
      bit         done     = 1'b0;
      int         consumed = 0;
      fork
         begin : drv
            int         lat;
            logic [1:0] w;
            logic       prev;
            for (int k = 0; k < n; k++) begin
               w = 2'($urandom_range(0, 3));
               exp_q.push_back(w);
               if (tp) begin
                  prev     = tp_if.ack;
                  tp_rails = tp_next(tp_rails, w);
                  tp_if.in = tp_rails;
                  wait_ack(1'b1, ~prev, 300, lat);
               end else begin
                  fp_if.in = fp_rails(w);
                  wait_ack(1'b0, 1'b1, 300, lat);
                  if (lat != 0) begin
                     fp_if.in = '0;
                     wait_ack(1'b0, 1'b0, 300, lat);
                  end
               end
               if (lat == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rand_ack_timeout: enc_tp=%0d token %0d, ack never answered", tp, k);
                  break;
               end
            end
            done = 1'b1;
         end
         begin : con
            int guard = 0;
            while (!(done && exp_q.size() == 0) && guard < 20000) begin
               @(negedge clk);
               guard++;
               if (tp) tp_if.ready_i = 1'($urandom_range(0, 1));
               else    fp_if.ready_i = 1'($urandom_range(0, 1));
               if ((tp ? (tp_if.valid_o && tp_if.ready_i) : (fp_if.valid_o && fp_if.ready_i)) === 1'b1) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL rand_extra: enc_tp=%0d got unexpected word %b", tp,
                              tp ? tp_if.data_o : fp_if.data_o);
                  end else begin
                     if ((tp ? tp_if.data_o : fp_if.data_o) !== exp_q[0]) begin
                        failures++;
                        $display("FAIL rand_data: enc_tp=%0d got %b, want %b", tp,
                                 tp ? tp_if.data_o : fp_if.data_o, exp_q[0]);
                     end
                     void'(exp_q.pop_front());
                     consumed++;
                  end
               end
            end
         end
      join
      @(negedge clk);
      fp_if.ready_i = 1'b1;
      tp_if.ready_i = 1'b1;
      checks++;
      if (consumed != n || (tp ? tp_if.err_o : fp_if.err_o) !== 1'b0) begin
         failures++;
         $display("FAIL rand_count: enc_tp=%0d consumed %0d words err=%b, want %0d err=0",
                  tp, consumed, tp ? tp_if.err_o : fp_if.err_o, n);
      end
   endtask

   task automatic test_errors();
      int lat;
      do_reset();
      fp_if.ready_i = 1'b0;
      fp_if.in      = fp_rails(2'b10);
      wait_valid(1'b0, lat);
      fp_if.in = '0;
      wait_ack(1'b0, 1'b0, 12, lat);
      fp_if.in = 4'b0111;
      repeat (6) @(negedge clk);
      checks++;
      if (fp_if.err_o !== 1'b1 || fp_if.ack !== 1'b0 || fp_if.valid_o !== 1'b1 || fp_if.data_o !== 2'b10) begin
         failures++;
         $display("FAIL fp_illegal: got err=%b ack=%b valid=%b data=%b, want 1/0/1/10",
                  fp_if.err_o, fp_if.ack, fp_if.valid_o, fp_if.data_o);
      end
      fp_if.ready_i = 1'b1;
      @(negedge clk);
      fp_if.in = fp_rails(2'b11);
      repeat (8) @(negedge clk);
      checks++;
      if (fp_if.valid_o !== 1'b0 || fp_if.ack !== 1'b0 || fp_if.err_o !== 1'b1) begin
         failures++;
         $display("FAIL fp_hold: got valid=%b ack=%b err=%b, want 0/0/1",
                  fp_if.valid_o, fp_if.ack, fp_if.err_o);
      end
      tp_if.in = 4'b1100;
      repeat (6) @(negedge clk);
      checks++;
      if (tp_if.err_o !== 1'b1 || tp_if.valid_o !== 1'b0 || tp_if.ack !== 1'b0) begin
         failures++;
         $display("FAIL tp_illegal: got err=%b valid=%b ack=%b, want 1/0/0",
                  tp_if.err_o, tp_if.valid_o, tp_if.ack);
      end
      do_reset();
      checks++;
      if ({fp_if.err_o, tp_if.err_o, fp_if.ack, fp_if.valid_o, fp_if.data_o} !== 6'b0) begin
         failures++;
         $display("FAIL err_reset: got fp_err=%b tp_err=%b ack=%b valid=%b data=%b, want all 0",
                  fp_if.err_o, tp_if.err_o, fp_if.ack, fp_if.valid_o, fp_if.data_o);
      end
   endtask

   task automatic test_reset_mid_token();
      int lat;
      fp_if.ready_i = 1'b0;
      fp_if.in      = fp_rails(2'b01);
      wait_valid(1'b0, lat);
      rst      = 1'b1;
      fp_if.in = '0;
      @(negedge clk);
      checks++;
      if (fp_if.valid_o !== 1'b0 || fp_if.ack !== 1'b0 || fp_if.err_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: got valid=%b ack=%b err=%b, want 0/0/0",
                  fp_if.valid_o, fp_if.ack, fp_if.err_o);
      end
      rst           = 1'b0;
      fp_if.ready_i = 1'b1;
      repeat (2) @(negedge clk);
      fp_if.in = fp_rails(2'b10);
      wait_valid(1'b0, lat);
      checks++;
      if (lat !== LAT || fp_if.data_o !== 2'b10 || fp_if.ack !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_token: got lat=%0d data=%b ack=%b, want lat=%0d data=10 ack=1",
                  lat, fp_if.data_o, fp_if.ack, LAT);
      end
      fp_if.in = '0;
      wait_ack(1'b0, 1'b0, 12, lat);
   endtask

   initial begin
      test_reset();
      test_fp_basic();
      test_tp_basic();
      test_backpressure();
      test_skew();
      test_random(1'b0, 24);
      test_random(1'b1, 24);
      test_errors();
      test_reset_mid_token();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dual_rail_rx.md
Name: dual_rail_rx

Overview:
- Clocked receiver that terminates a WIDTH-bit dual-rail link at the synchronous boundary.
- Synchronises the rails and detects codeword completion per ENC protocol ("FP" four-phase RTZ or "TP" two-phase transition).
- Decodes the codeword to binary and presents it on a valid/ready interface.
- Returns the link acknowledge to the upstream dual-rail stage. It is the sink counterpart of the dual-rail driver/logic stages.

Parameters:
- ENC, "TP", protocol: "FP" = four-phase return-to-spacer; "TP" = two-phase transition signalling.
- WIDTH, 2, number of dual-rail bits in the bundle.
- SYNC_STAGES, 2, flop stages on every rail (minimum 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in  in  [WIDTH-1:0][1:0]  dual-rail bundle, asynchronous to clk; rail[1] = true, rail[0] = false.
- ack  out  1  acknowledge to the upstream sender.
- data_o  out  WIDTH  decoded binary word.
- valid_o  out  1  data_o holds an unconsumed word.
- ready_i  in  1  downstream accepts the word when valid_o && ready_i.
- err_o  out  1  sticky protocol violation flag.

Behaviour:
- Reset values: ack=0, valid_o=0, data_o=0, err_o=0. The TP reference register is cleared to all rails 0, the sync chain is cleared, and the FSM goes to WAIT_DATA. Reset mid-operation aborts any token and drops a pending word.
- Sampling: every rail passes through SYNC_STAGES flops to give synced sample S. The previous sample is S_d.
- A condition is "stable" only when it holds in both S and S_d with S == S_d. This filters rail skew.
- FP decode, per bit: 00 = spacer, 01 = 0, 10 = 1, 11 = illegal.
  - Complete = no bit is spacer.
  - Empty = all bits spacer.
- TP decode, per bit: compare S with REF, the rails at the last accepted token.
  - True rail toggled only = 1.
  - False rail toggled only = 0.
  - Neither toggled = incomplete.
  - Both toggled = illegal.
- FSM states: WAIT_DATA, HOLD, WAIT_SPACER (FP only).
- WAIT_DATA: when a stable complete codeword is seen and valid_o=0, or valid_o && ready_i in the same cycle:
  - capture decoded bits into data_o and set valid_o=1;
  - FP: set ack=1 and go to WAIT_SPACER;
  - TP: toggle ack, load REF<=S, and stay in WAIT_DATA;
  - if the output is occupied and not being consumed, stay and keep ack unchanged (backpressure).
- Latency from the last rail edge at in to valid_o: SYNC_STAGES+2 clk edges.
- WAIT_SPACER (FP): on stable empty, set ack=0 and return to WAIT_DATA. A bit changing directly between 01 and 10 without a spacer is an error.
- HOLD: entered only when err_o=1. All state is frozen until rst.
- Output handshake: valid_o clears on valid_o && ready_i unless a new capture happens in the same cycle, in which case valid_o stays 1 with new data. data_o is stable while valid_o=1 && !ready_i.
- Error: an illegal bit in a stable sample sets err_o=1 and moves the FSM to HOLD. ack holds its current value. Any word already in data_o/valid_o remains drainable.
- Transient illegal values that never become stable are ignored.
- WIDTH=1 must work. There is no arithmetic; decode is bitwise only.

Test Plan:
- FP, WIDTH=2, ready_i=1: drive bits {1,0} (rails 10,01) → data_o=2'b10 and valid_o pulses after SYNC_STAGES+2 cycles, ack=1. Then drive spacer 00,00 → ack=0 within SYNC_STAGES+2 cycles.
- TP, WIDTH=2, ready_i=1: toggle the true rail of bit0 and the false rail of bit1 → data_o=2'b01 and ack toggles 0→1. Then toggle the true rails of both bits → data_o=2'b11 and ack toggles 1→0.
- Backpressure (FP), ready_i=0: send word 2'b11 then spacer then 2'b00 → after spacer, ack=0. The second word is held off (ack stays 0, data_o=2'b11) until ready_i=1. Then data_o=2'b00 and ack=1.
- Skew: in FP, bit1 rail goes active 3 cycles after bit0 → no capture until both are stable. A single capture occurs with correct data and no err_o.
- Errors:
  - FP bit0 held at 11 → err_o=1, ack frozen, valid_o not asserted for new data.
  - TP both rails of bit1 toggled → err_o=1.
  - After rst, all outputs return to 0.
- Reset mid-token: assert rst while in WAIT_SPACER with valid_o=1 → next cycle valid_o=0, ack=0, err_o=0. A fresh FP token decodes correctly afterwards.
